// File: rtl/dff_rs_pkg.sv
// Shared defaults for the dff_rs storage primitive.
package dff_rs_pkg;

    // Default register width: a single-bit flip-flop.
    localparam int unsigned DefaultWidth = 1;

    // Every bit of the default reset value is zero.
    localparam logic DefaultResetBit = 1'b0;

endpackage

// File: rtl/dff_rs_cell.sv
// One-bit flip-flop: async active-high reset, then sync clear > set > load enable.
module dff_rs_cell
    import dff_rs_pkg::*;
#(
    parameter logic RESET_VAL = DefaultResetBit
) (
    input  logic clk,
    input  logic reset,
    input  logic set_n,
    input  logic clr_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next state: clear wins over set, and both act regardless of en.
    always_comb begin
        q_d = q_q;
        if (!clr_n) begin
            q_d = 1'b0;
        end else if (!set_n) begin
            q_d = 1'b1;
        end else if (en) begin
            q_d = d;
        end
    end

    // State register; reset takes effect immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dff_rs.sv
// WIDTH-bit register built from identical dff_rs_cell bit cells.
module dff_rs
    import dff_rs_pkg::*;
#(
    parameter int unsigned       WIDTH     = DefaultWidth,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{DefaultResetBit}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_n,
    input  logic             clr_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    // One cell per bit; all cells share the control inputs so bits update together.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_rs_cell #(
            .RESET_VAL (RESET_VAL[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .set_n (set_n),
            .clr_n (clr_n),
            .en    (en),
            .d     (d[i]),
            .q     (q[i])
        );
    end

    // Complement output follows q combinationally, including during reset.
    assign q_n = ~q;

endmodule

// File: tb/tb_dff_rs.sv
// Self-checking bench: a default 1-bit instance and an 8-bit instance with reset value A5.
module tb_dff_rs;

    logic       clk = 1'b0;

    logic       rst1, set_n1, clr_n1, en1, d1;
    logic       q1, q_n1;

    logic       rst8, set_n8, clr_n8, en8;
    logic [7:0] d8, q8, q_n8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       set_n;
        logic       clr_n;
        logic       en;
        logic [7:0] d;
        logic [7:0] exp_q;
        string      name;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    dff_rs u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .set_n (set_n1),
        .clr_n (clr_n1),
        .en    (en1),
        .d     (d1),
        .q     (q1),
        .q_n   (q_n1)
    );

    dff_rs #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (rst8),
        .set_n (set_n8),
        .clr_n (clr_n8),
        .en    (en8),
        .d     (d8),
        .q     (q8),
        .q_n   (q_n8)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Checks q and q_n of the 8-bit instance against one expected q.
    task automatic check8(input string name, input logic [7:0] exp);
        check({name, " q"}, q8, exp);
        check({name, " q_n"}, q_n8, ~exp);
    endtask

    task automatic check1(input string name, input logic exp);
        check({name, " q"}, {7'd0, q1}, {7'd0, exp});
        check({name, " q_n"}, {7'd0, q_n1}, {7'd0, ~exp});
    endtask

    initial begin
        logic exp1;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'h3C, "load 3C"};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h3C, "hold en0"};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h55, 8'hFF, "set en0"};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h55, 8'h00, "clr en0"};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'hC3, 8'hC3, "load C3"};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h00, "clr beats set"};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h12, 8'hFF, "set beats en"};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h81, "load 81"};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h81, "hold 81"};

        rst1 = 1'b1; set_n1 = 1'b1; clr_n1 = 1'b1; en1 = 1'b0; d1 = 1'b0;
        rst8 = 1'b1; set_n8 = 1'b1; clr_n8 = 1'b1; en8 = 1'b0; d8 = 8'h00;

        // Reset state before any clock edge.
        #1;
        check1("reset w1", 1'b0);
        check8("reset w8", 8'hA5);

        @(negedge clk);
        rst1 = 1'b0;
        rst8 = 1'b0;

        // Table-driven vectors on the 8-bit instance.
        for (int i = 0; i < 9; i++) begin
            set_n8 = vecs[i].set_n;
            clr_n8 = vecs[i].clr_n;
            en8    = vecs[i].en;
            d8     = vecs[i].d;
            @(posedge clk);
            #1;
            check8(vecs[i].name, vecs[i].exp_q);
            @(negedge clk);
        end

        // Mid-cycle reset discards a freshly loaded value.
        set_n8 = 1'b1; clr_n8 = 1'b1; en8 = 1'b1; d8 = 8'h3C;
        @(posedge clk);
        #1;
        check8("preload 3C", 8'h3C);
        #2;
        rst8 = 1'b1;
        #1;
        check8("async reset mid-cycle", 8'hA5);
        @(negedge clk);
        d8 = 8'hFF;
        @(posedge clk);
        #1;
        check8("reset held over edge", 8'hA5);
        @(negedge clk);
        rst8 = 1'b0;
        @(posedge clk);
        #1;
        check8("first edge after release", 8'hFF);

        // d changes between edges have no effect until the next rising edge.
        d8 = 8'h00;
        #2;
        check8("d change mid-cycle", 8'hFF);
        @(negedge clk);
        d8 = 8'h0F;
        #2;
        check8("d change before edge", 8'hFF);
        @(posedge clk);
        #1;
        check8("d sampled at edge", 8'h0F);

        // 1-bit instance: reset pulse, then set and clear both low with d toggling.
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        check1("w1 reset pulse", 1'b0);
        #1;
        rst1 = 1'b0;
        set_n1 = 1'b0; clr_n1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check1("w1 clear dominates set", 1'b0);
            @(negedge clk);
            d1 = ~d1;
        end

        // Clear released, set still low: ones regardless of d.
        clr_n1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check1("w1 set", 1'b1);
            @(negedge clk);
            d1 = ~d1;
        end

        // Both released: q follows d sampled at each edge.
        set_n1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp1 = d1;
            @(posedge clk);
            #1;
            check1("w1 follow d", exp1);
            @(negedge clk);
            d1 = ~d1;
        end

        // Hold with en low even as d keeps toggling.
        en1 = 1'b0;
        exp1 = q1 ? 1'b1 : 1'b0;
        exp1 = ~d1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check1("w1 hold", exp1);
            @(negedge clk);
            d1 = ~d1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
